// File: rtl/lsu_bus_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus_master_pkg
//  Brief    : DM_op encodings, LSU state encodings and access legality helper.
//  Revision : 1.0
// ============================================================================
package lsu_bus_master_pkg;

    localparam logic [2:0] c_dm_w  = 3'd0;
    localparam logic [2:0] c_dm_h  = 3'd1;
    localparam logic [2:0] c_dm_hu = 3'd2;
    localparam logic [2:0] c_dm_b  = 3'd3;
    localparam logic [2:0] c_dm_bu = 3'd4;

    localparam logic [1:0] c_lsu_idle = 2'd0;
    localparam logic [1:0] c_lsu_req  = 2'd1;
    localparam logic [1:0] c_lsu_wait = 2'd2;
    localparam logic [1:0] c_lsu_done = 2'd3;

    // Alignment and op/direction legality; the address range is checked by the caller.
    function automatic logic dm_legal(input logic [2:0] op, input logic wr, input logic [1:0] addr_lo);
        logic ok;
        case (op)
            c_dm_w:  ok = (addr_lo == 2'b00);
            c_dm_h:  ok = ~addr_lo[0];
            c_dm_hu: ok = ~addr_lo[0] & ~wr;
            c_dm_b:  ok = 1'b1;
            c_dm_bu: ok = ~wr;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_bus_master_lane.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus_master_lane
//  Brief    : Byte-enable / write-lane replication and read lane extract+extend.
//  Revision : 1.0
// ============================================================================
module lsu_bus_master_lane
    import lsu_bus_master_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_ext
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_be        = 4'b0000;
        o_wdata_rep = i_wdata;
        o_rdata_ext = i_rdata;
        case (i_op)
            c_dm_w: o_be = 4'b1111;
            c_dm_h, c_dm_hu: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata_ext = {{16{w_half[15] & (i_op == c_dm_h)}}, w_half};
            end
            c_dm_b, c_dm_bu: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{w_byte[7] & (i_op == c_dm_b)}}, w_byte};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus_master
//  Brief    : M-stage load/store initiator driving a valid/ready data bus.
//  Revision : 1.0
// ============================================================================
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
    parameter int          TIMEOUT    = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        addr_exc,
    output logic        bus_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    logic [1:0]  r_state, w_state_nxt;
    logic [7:0]  r_cnt;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic        w_legal, w_accept, w_busy, w_timeout, w_handshake, w_rsp;
    logic [2:0]  w_lane_op;
    logic [1:0]  w_lane_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep, w_rdata_ext;

    assign w_legal     = dm_legal(req_op, req_wr, req_addr[1:0]) && (req_addr < ADDR_LIMIT);
    assign w_accept    = (r_state == c_lsu_idle) && req_valid && w_legal;
    assign w_busy      = (r_state == c_lsu_req) || (r_state == c_lsu_wait);
    assign w_timeout   = w_busy && (r_cnt == c_timeout);
    assign w_handshake = (r_state == c_lsu_req) && !w_timeout && bus_ready;
    assign w_rsp       = (r_state == c_lsu_wait) && !w_timeout && bus_rvalid;

    // Lane unit sees the incoming request in IDLE and the latched access afterwards.
    assign w_lane_op      = (r_state == c_lsu_idle) ? req_op        : r_op;
    assign w_lane_addr_lo = (r_state == c_lsu_idle) ? req_addr[1:0] : r_addr_lo;

    lsu_bus_master_lane u_lane (
        .i_op        (w_lane_op),
        .i_addr_lo   (w_lane_addr_lo),
        .i_wdata     (req_wdata),
        .i_rdata     (bus_rdata),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_lsu_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_lsu_idle: if (w_accept) w_state_nxt = c_lsu_req;
            c_lsu_req: begin
                if (w_timeout)        w_state_nxt = c_lsu_done;
                else if (w_handshake) w_state_nxt = bus_wr ? c_lsu_done : c_lsu_wait;
            end
            c_lsu_wait: if (w_timeout || w_rsp) w_state_nxt = c_lsu_done;
            default:    w_state_nxt = c_lsu_idle;
        endcase
    end

    // IDLE outputs are gated by reset so a held request cannot leak through during reset.
    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        addr_exc  = 1'b0;
        bus_err   = 1'b0;
        bus_valid = 1'b0;
        case (r_state)
            c_lsu_idle: begin
                stall    = reset & req_valid & w_legal;
                addr_exc = reset & req_valid & ~w_legal;
            end
            c_lsu_req: begin
                stall     = 1'b1;
                bus_valid = ~w_timeout;
                bus_err   = w_timeout;
            end
            c_lsu_wait: begin
                stall   = 1'b1;
                bus_err = w_timeout;
            end
            default: done = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_wr    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            load_data <= 32'd0;
            r_op      <= 3'd0;
            r_addr_lo <= 2'd0;
            r_cnt     <= 8'd0;
        end else begin
            if (w_accept) begin
                bus_wr    <= req_wr;
                bus_addr  <= {req_addr[31:2], 2'b00};
                bus_be    <= w_be;
                bus_wdata <= w_wdata_rep;
                r_op      <= req_op;
                r_addr_lo <= req_addr[1:0];
                r_cnt     <= 8'd0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_timeout)  load_data <= 32'd0;
            else if (w_rsp) load_data <= w_rdata_ext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_bus_master
//  Brief    : Directed + randomized self-checking bench with arithmetic reference model.
//  Revision : 1.0
// ============================================================================
module tb_lsu_bus_master;
    import lsu_bus_master_pkg::*;

    localparam logic [31:0] LIMIT = 32'h0000_4000;
    localparam int          TMO   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_wr;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, addr_exc, bus_err, bus_valid, bus_wr;
    logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_rvalid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.ADDR_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wr(req_wr), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .done(done),
        .addr_exc(addr_exc), .bus_err(bus_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: access size in bytes, 0 = bad op
    function automatic int op_size(input logic [2:0] op);
        case (op)
            c_dm_w:          return 4;
            c_dm_h, c_dm_hu: return 2;
            c_dm_b, c_dm_bu: return 1;
            default:         return 0;
        endcase
    endfunction

    function automatic bit model_legal(input logic wr, input logic [2:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        if (sz == 0) return 1'b0;
        if ((int'(addr[1:0]) % sz) != 0) return 1'b0;
        if (addr >= LIMIT) return 1'b0;
        if (wr && (op == c_dm_hu || op == c_dm_bu)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        return 4'(((1 << sz) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int sz = op_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int          sz = op_size(op);
        logic [31:0] v, mask;
        v = rd >> (8 * int'(addr[1:0]));
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = v & mask;
        if ((op == c_dm_h || op == c_dm_b) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One pipeline access; begins at the next falling edge, responder delays in cycles.
    task automatic access(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rd, input string name);
        bit legal = model_legal(wr, op, addr);
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        check1({name, ".exc"},   addr_exc,  !legal);
        check1({name, ".stall"}, stall,     legal);
        check1({name, ".valid"}, bus_valid, 1'b0);
        if (!legal) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check1({name, ".exc_clr"}, addr_exc,  1'b0);
            check1({name, ".novalid"}, bus_valid, 1'b0);
            return;
        end
        for (int n = 0; n <= rdy_dly; n++) begin
            @(negedge clk);
            bus_ready  = (n == rdy_dly);
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
            #1;
            check1 ({name, ".req_valid"}, bus_valid, 1'b1);
            check1 ({name, ".req_stall"}, stall,     1'b1);
            check1 ({name, ".wr"},        bus_wr,    wr);
            check32({name, ".addr"},      bus_addr,  addr & ~32'h3);
            check32({name, ".be"},        {28'd0, bus_be}, {28'd0, model_be(op, addr)});
            check32({name, ".wdata"},     bus_wdata, model_wdata(op, wd));
        end
        if (!wr) begin
            for (int n = 0; n <= rv_dly; n++) begin
                @(negedge clk);
                bus_ready  = 1'b0;
                bus_rvalid = (n == rv_dly);
                bus_rdata  = (n == rv_dly) ? rd : $urandom;
                #1;
                check1({name, ".wait_valid"}, bus_valid, 1'b0);
                check1({name, ".wait_stall"}, stall,     1'b1);
                check1({name, ".wait_done"},  done,      1'b0);
            end
        end
        // Request left asserted in DONE: it must not be taken this cycle.
        @(negedge clk);
        bus_ready  = 1'b0;
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
        #1;
        check1({name, ".done"},       done,    1'b1);
        check1({name, ".done_stall"}, stall,   1'b0);
        check1({name, ".done_err"},   bus_err, 1'b0);
        if (!wr) check32({name, ".load"}, load_data, model_load(op, addr, rd));
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_op = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        check1 ("rst.stall", stall, 1'b0);
        check1 ("rst.done",  done,  1'b0);
        check1 ("rst.exc",   addr_exc, 1'b0);
        check1 ("rst.err",   bus_err,  1'b0);
        check1 ("rst.valid", bus_valid, 1'b0);
        check1 ("rst.wr",    bus_wr,    1'b0);
        check32("rst.addr",  bus_addr,  32'd0);
        check32("rst.be",    {28'd0, bus_be}, 32'd0);
        check32("rst.wdata", bus_wdata, 32'd0);
        check32("rst.load",  load_data, 32'd0);
        reset = 1'b1;

        access(1'b1, c_dm_w,  32'h10, 32'hDEAD_BEEF, 1, 0, 32'd0, "sw");
        access(1'b1, c_dm_b,  32'h23, 32'h0000_00A5, 0, 0, 32'd0, "sb");
        access(1'b0, c_dm_h,  32'h42, 32'd0, 0, 2, 32'h8001_7FFF, "lh");
        access(1'b0, c_dm_hu, 32'h42, 32'd0, 1, 2, 32'h8001_7FFF, "lhu");
        access(1'b0, c_dm_b,  32'h41, 32'd0, 0, 0, 32'h8001_7FFF, "lb");
        check32("lb.value", load_data, 32'h0000_007F);

        // Reset asserted while a load sits in WAIT, request still held.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_op = c_dm_w; req_addr = 32'h80;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        bus_ready = 1'b1;
        #1 check1("midrst.req", bus_valid, 1'b1);
        @(negedge clk);
        bus_ready = 1'b0;
        #1 check1("midrst.wait_stall", stall, 1'b1);
        reset = 1'b0;
        #1;
        check1 ("midrst.stall", stall,     1'b0);
        check1 ("midrst.valid", bus_valid, 1'b0);
        check1 ("midrst.done",  done,      1'b0);
        check32("midrst.addr",  bus_addr,  32'd0);
        check32("midrst.be",    {28'd0, bus_be}, 32'd0);
        check32("midrst.load",  load_data, 32'd0);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        access(1'b0, c_dm_w, 32'h84, 32'd0, 1, 1, 32'h1234_5678, "lw_after_rst");

        access(1'b0, c_dm_w,  32'h6,    32'd0, 0, 0, 32'd0, "lw_mis");
        access(1'b1, c_dm_h,  32'h3,    32'd1, 0, 0, 32'd0, "sh_mis");
        access(1'b1, c_dm_bu, 32'h10,   32'd1, 0, 0, 32'd0, "sbu");
        access(1'b1, c_dm_w,  LIMIT,    32'd1, 0, 0, 32'd0, "sw_range");
        access(1'b0, 3'd6,    32'h8,    32'd0, 0, 0, 32'd0, "badop");
        access(1'b0, c_dm_b,  LIMIT - 32'd1, 32'd0, 0, 0, 32'hC300_0000, "lb_top");

        // Timeout: bus_ready never comes.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_op = c_dm_w; req_addr = 32'h100;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1 check1("tmo.stall0", stall, 1'b1);
        for (int n = 1; n <= TMO; n++) begin
            @(negedge clk);
            #1;
            check1("tmo.valid", bus_valid, 1'b1);
            check1("tmo.noerr", bus_err,   1'b0);
        end
        @(negedge clk);
        #1;
        check1("tmo.err",       bus_err,   1'b1);
        check1("tmo.valid_low", bus_valid, 1'b0);
        check1("tmo.stall",     stall,     1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check1 ("tmo.done",    done,      1'b1);
        check1 ("tmo.err_clr", bus_err,   1'b0);
        check32("tmo.load",    load_data, 32'd0);
        @(negedge clk);
        #1 check1("tmo.idle", stall, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  op;
            logic        wr;
            logic [31:0] a;
            op = 3'($urandom_range(0, 5));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = LIMIT - 32'd8 + 32'($urandom_range(0, 15));
            else                           a = 32'($urandom_range(0, 32'h3FFF));
            access(wr, op, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom, "rand");
        end

        @(negedge clk);
        req_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
